// File: rtl/axis_daq_pkg.sv
// Shared types and constants for the DAQ BRAM-to-AXI-Stream reader.
// Used by axis_daq_reader and its skid FIFO.
package axis_daq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int FIFO_DEPTH      = 2;

endpackage

// File: rtl/axis_daq_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides; carries {last, data} words
// returned by the BRAM so the stream side can stall without losing data.
module axis_daq_skid_fifo
  import axis_daq_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_m_valid = (r_count != 2'd0);
  assign w_pop     = o_m_valid && i_m_ready;
  // A full FIFO can still accept a word in the same cycle it releases one.
  assign o_s_ready = (r_count != 2'(FIFO_DEPTH)) || i_m_ready;
  assign w_push    = i_s_valid && o_s_ready;
  assign o_m_data  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_s_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_daq_reader.sv
// Streams rd_length consecutive BRAM words (wrapping) out of AXI-Stream.
// Optional macro AXIS_DAQ_READER_BYTESWAP_EN byte-reverses each word.
module axis_daq_reader
  import axis_daq_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int BRAM_DATA_WIDTH = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       rd_start,
  input  logic [BRAM_ADDR_WIDTH-1:0] rd_start_addr,
  input  logic [BRAM_ADDR_WIDTH:0]   rd_length,
  output logic [31:0]                rd_status,
  output logic                       bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_portb_rddata,
  output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  rd_state_t     r_state;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_remaining;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          r_busy;
  logic          r_done;

  logic          w_start_issue;
  logic          w_read_issue;
  logic          w_issue;
  logic          w_issue_last;
  logic          w_fifo_s_ready;
  logic          w_fifo_pop;
  logic [1:0]    w_fifo_count;
  logic [2:0]    w_pending;
  logic [DW-1:0] w_wr_data;
  logic [DW:0]   w_fifo_out;

  assign bram_portb_clk = aclk;

  // The first word is addressed in the start cycle itself so data reaches
  // the stream two cycles later.
  assign w_start_issue   = aresetn && (r_state == IDLE) && rd_start && (rd_length != '0);
  assign bram_portb_addr = w_start_issue ? rd_start_addr : r_addr;

  // Occupancy counts the word leaving this cycle as gone, keeping full rate.
  assign w_fifo_pop   = m_axis_tvalid && m_axis_tready;
  assign w_pending    = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_fifo_pop};
  assign w_read_issue = aresetn && (r_state == READ) && (r_remaining != '0) &&
                        (w_pending < 3'(FIFO_DEPTH)) && w_fifo_s_ready;
  assign w_issue      = w_start_issue || w_read_issue;
  assign w_issue_last = w_start_issue ? (rd_length == LEN_ONE) : (r_remaining == LEN_ONE);

`ifdef AXIS_DAQ_READER_BYTESWAP_EN
  localparam int NBYTES = DW / 8;
  always_comb begin
    w_wr_data = '0;
    for (int b = 0; b < NBYTES; b++) begin
      w_wr_data[b*8 +: 8] = bram_portb_rddata[(NBYTES-1-b)*8 +: 8];
    end
  end
`else
  assign w_wr_data = bram_portb_rddata;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_issue_last;
      if (w_issue) begin
        r_addr <= bram_portb_addr + AW'(1);
      end
      case (r_state)
        IDLE: begin
          if (rd_start) begin
            if (rd_length == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_remaining <= rd_length - LEN_ONE;
              r_state     <= READ;
              r_busy      <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_read_issue) begin
            r_remaining <= r_remaining - LEN_ONE;
          end
          if ((r_remaining == '0) || (w_read_issue && (r_remaining == LEN_ONE))) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_fifo_pop && m_axis_tlast) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          if (!rd_start) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_status                  = '0;
    rd_status[STATUS_BUSY_BIT] = r_busy;
    rd_status[STATUS_DONE_BIT] = r_done;
  end

  axis_daq_skid_fifo #(
    .WIDTH (DW + 1)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_s_data  ({r_inflight_last, w_wr_data}),
    .i_s_valid (r_inflight),
    .o_s_ready (w_fifo_s_ready),
    .o_m_data  (w_fifo_out),
    .o_m_valid (m_axis_tvalid),
    .i_m_ready (m_axis_tready),
    .o_count   (w_fifo_count)
  );

  assign m_axis_tlast = w_fifo_out[DW];
  assign m_axis_tdata = w_fifo_out[DW-1:0];

endmodule

// File: doc/axis_daq_reader.md
AXIS_DAQ_READER -- requirements
Module: axis_daq_reader

Interface
REQ-001 SHALL have parameter BRAM_ADDR_WIDTH, default 16, the BRAM word-address width (AW).
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default 16, the BRAM word and m_axis_tdata width (DW).
REQ-003 SHALL have port aclk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port rd_start, input, 1 bit: single-cycle start request.
REQ-006 SHALL have port rd_start_addr, input, AW bits: first BRAM word to read.
REQ-007 SHALL have port rd_length, input, AW+1 bits: number of words to read; 0 means none.
REQ-008 SHALL have port rd_status, output, 32 bits: [0] busy, [1] done, [31:2] zero.
REQ-009 SHALL have ports bram_portb_clk (output, 1 bit), bram_portb_addr (output, AW bits) and bram_portb_rddata (input, DW bits), read-only, 1-cycle read latency.
REQ-010 SHALL have ports m_axis_tdata (output, DW bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit).

Function
REQ-011 SHALL drive bram_portb_clk = aclk.
REQ-012 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-013 IDLE->READ on rd_start=1 with rd_length!=0; SHALL latch rd_start_addr and rd_length in that cycle.
REQ-014 IDLE->DONE on rd_start=1 with rd_length=0; SHALL emit no beats.
REQ-015 READ->DRAIN in the cycle the last read address is issued.
REQ-016 DRAIN->DONE in the cycle the tlast beat is accepted (tvalid & tready).
REQ-017 DONE->IDLE when rd_start=0; DONE SHALL hold done=1 until then.
REQ-018 SHALL ignore rd_start while busy (READ or DRAIN).
REQ-019 busy SHALL be 1 exactly in READ and DRAIN.
REQ-020 Read address SHALL increment by 1 per issued read, modulo 2^AW (wrap from all-ones to 0).
REQ-021 rd_length = 2^AW SHALL read the entire buffer once, starting at rd_start_addr.
REQ-022 SHALL buffer returned words in a 2-entry FIFO.
REQ-023 SHALL issue a read only if FIFO occupancy plus in-flight reads is less than 2.
REQ-024 SHALL never drop or duplicate a word under any m_axis_tready pattern.
REQ-025 m_axis_tvalid SHALL equal FIFO-not-empty; tdata and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-026 m_axis_tlast SHALL be 1 only on beat number rd_length (the final beat).
REQ-027 With tready held at 1, first tvalid SHALL occur 2 cycles after the rd_start cycle, then 1 beat/cycle.
REQ-028 Beats SHALL be in address order, unmodified unless the REQ-033 macro is defined.

Reset
REQ-029 On aresetn=0 at a clock edge: state=IDLE, FIFO empty, in-flight count=0.
REQ-030 On aresetn=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, bram_portb_addr=0, rd_status=0.
REQ-031 Reset mid-transfer SHALL abort immediately; no beat SHALL follow until a new rd_start.
REQ-032 In-flight BRAM data arriving after reset SHALL be discarded.

Configuration
REQ-033 Macro AXIS_DAQ_READER_BYTESWAP_EN defined: m_axis_tdata SHALL be the byte-reversed BRAM word (DW a multiple of 8); undefined: passed through unchanged.

Structure
REQ-034 Shared package axis_daq_pkg SHALL hold the reader state typedef, rd_status bit-index constants and the FIFO depth constant (2).
REQ-035 The FIFO SHALL be sub-module axis_daq_skid_fifo (2 entries, valid/ready both sides, carrying data+last).

Verification
REQ-036 start_addr=0x0010, length=8, tready=1: 8 beats of words 0x10..0x17, tlast on beat 8, done=1 after it.
REQ-037 start_addr=0xFFFE, length=4: beats from 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-038 length=16, tready toggling 1/0 every cycle: all 16 words exactly once, in order, stable while stalled.
REQ-039 length=0: no tvalid, done=1 one cycle after start; rd_start pulsed while busy: no effect.
REQ-040 aresetn=0 after beat 3 of length=10: tvalid=0 next cycle, no further beats, rd_status=0.
REQ-041 With AXIS_DAQ_READER_BYTESWAP_EN defined, BRAM word 0x1234 SHALL output 0x3412.
